// File: rtl/elbert_probe_tx.sv
// Probe snapshot transmitter: on capture, latches the probe inputs and sends one
// 7-byte 8N1 UART frame (sync byte, payload, XOR checksum) on a registered tx line.
module elbert_probe_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        capture,
  input  logic        probe1,
  input  logic [15:0] probe2,
  input  logic [7:0]  probe4,
  input  logic [7:0]  probe5,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ZERO = CW'(0);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          snap_p1_q, snap_p1_d;
  logic [15:0]   snap_p2_q, snap_p2_d;
  logic [7:0]    snap_p4_q, snap_p4_d;
  logic [7:0]    snap_p5_q, snap_p5_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    cur_byte_s;
  logic          bit_end_s;

  // The sync byte 0xA5 is deliberately excluded from the checksum.
  function automatic logic [7:0] payload_xor(input logic p1, input logic [15:0] p2,
                                             input logic [7:0] p4, input logic [7:0] p5);
    payload_xor = {7'b0000000, p1} ^ p2[15:8] ^ p2[7:0] ^ p4 ^ p5;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic p1,
                                            input logic [15:0] p2, input logic [7:0] p4,
                                            input logic [7:0] p5);
    case (idx)
      3'd0:    frame_byte = 8'hA5;
      3'd1:    frame_byte = {7'b0000000, p1};
      3'd2:    frame_byte = p2[15:8];
      3'd3:    frame_byte = p2[7:0];
      3'd4:    frame_byte = p4;
      3'd5:    frame_byte = p5;
      3'd6:    frame_byte = payload_xor(p1, p2, p4, p5);
      default: frame_byte = 8'hFF;
    endcase
  endfunction

  assign cur_byte_s = frame_byte(byte_idx_q, snap_p1_q, snap_p2_q, snap_p4_q, snap_p5_q);
  assign bit_end_s  = (baud_q == BAUD_LAST);

  // Next-state logic: tx_d is the level for the bit period starting at the next edge.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    snap_p1_d  = snap_p1_q;
    snap_p2_d  = snap_p2_q;
    snap_p4_d  = snap_p4_q;
    snap_p5_d  = snap_p5_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = BAUD_ZERO;
        if (capture) begin
          snap_p1_d  = probe1;
          snap_p2_d  = probe2;
          snap_p4_d  = probe4;
          snap_p5_d  = probe5;
          byte_idx_d = 3'd0;
          bit_idx_d  = 3'd0;
          state_d    = ST_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_d    = BAUD_ZERO;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
          tx_d      = cur_byte_s[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_d = BAUD_ZERO;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte_s[bit_idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          baud_d = BAUD_ZERO;
          if (byte_idx_q == 3'd6) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = ST_START;
            tx_d       = 1'b0;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = BAUD_ZERO;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; tx idles high.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      baud_q     <= BAUD_ZERO;
      byte_idx_q <= 3'd0;
      bit_idx_q  <= 3'd0;
      snap_p1_q  <= 1'b0;
      snap_p2_q  <= 16'h0000;
      snap_p4_q  <= 8'h00;
      snap_p5_q  <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      snap_p1_q  <= snap_p1_d;
      snap_p2_q  <= snap_p2_d;
      snap_p4_q  <= snap_p4_d;
      snap_p5_q  <= snap_p5_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_elbert_probe_tx.sv
// Scoreboard bench for elbert_probe_tx: stimulus pushes expected UART bytes, a tx
// decoder and a busy/frame_done monitor pop and compare independently.
module tb_elbert_probe_tx;
  localparam int C = 4;
  localparam int FRAME_CYC = 70 * C;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        capture;
  logic        probe1;
  logic [15:0] probe2;
  logic [7:0]  probe4;
  logic [7:0]  probe5;
  logic        tx;
  logic        busy;
  logic        frame_done;

  typedef struct {
    logic [7:0] b;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_done = 0;
  int   done_count = 0;
  logic samples [0:10*C-1];

  elbert_probe_tx #(.CLKS_PER_BIT(C)) dut (
    .clock(clock), .reset_n(reset_n), .capture(capture), .probe1(probe1),
    .probe2(probe2), .probe4(probe4), .probe5(probe5), .tx(tx), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference frame: sync byte, payload in order, then XOR of the five payload bytes.
  task automatic push_frame(input logic p1, input logic [15:0] p2, input logic [7:0] p4,
                            input logic [7:0] p5, input int first_gap);
    logic [7:0] bytes [0:6];
    exp_t e;
    bytes[0] = 8'hA5;
    bytes[1] = p1 ? 8'h01 : 8'h00;
    bytes[2] = p2 / 16'd256;
    bytes[3] = p2 % 16'd256;
    bytes[4] = p4;
    bytes[5] = p5;
    bytes[6] = 8'h00;
    for (int i = 1; i <= 5; i++) bytes[6] = bytes[6] ^ bytes[i];
    for (int i = 0; i < 7; i++) begin
      e.b   = bytes[i];
      e.gap = (i == 0) ? first_gap : 0;
      exp_q.push_back(e);
    end
    exp_done++;
  endtask

  task automatic start_frame(input logic p1, input logic [15:0] p2, input logic [7:0] p4,
                             input logic [7:0] p5);
    probe1 = p1; probe2 = p2; probe4 = p4; probe5 = p5;
    capture = 1'b1;
    push_frame(p1, p2, p4, p5, -1);
    tick();
    capture = 1'b0;
  endtask

  // mode 0: quiet; 1: fixed probe change plus capture at cycle 100; 2: random noise.
  task automatic run_frame(input logic p1, input logic [15:0] p2, input logic [7:0] p4,
                           input logic [7:0] p5, input int mode);
    start_frame(p1, p2, p4, p5);
    if (mode == 1) begin
      probe1 = 1'b0; probe2 = 16'hFFFF; probe4 = 8'hFF; probe5 = 8'hFF;
    end
    for (int i = 1; i < FRAME_CYC + 10; i++) begin
      if (mode == 1) capture = (i == 100);
      else if (mode == 2 && i < FRAME_CYC - 10) begin
        capture = 1'($urandom_range(0, 1));
        probe1  = 1'($urandom);
        probe2  = 16'($urandom);
        probe4  = 8'($urandom);
        probe5  = 8'($urandom);
      end else capture = 1'b0;
      tick();
    end
    capture = 1'b0;
  endtask

  // tx decoder: every bit window must be constant for exactly C samples.
  initial begin
    int nsamp;
    int idle_run;
    logic active;
    logic [7:0] data;
    logic ok_timing;
    exp_t e;
    active = 1'b0; nsamp = 0; idle_run = 0;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        active = 1'b0; idle_run = 0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1; samples[0] = 1'b0; nsamp = 1;
        end else if (tx === 1'b1) idle_run++;
      end else begin
        samples[nsamp] = tx;
        nsamp++;
        if (nsamp == 10 * C) begin
          ok_timing = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 1; j < C; j++)
              if (samples[k*C+j] !== samples[k*C]) ok_timing = 1'b0;
          for (int k = 0; k < 8; k++) data[k] = samples[(k+1)*C];
          check("bit_timing", {31'd0, ok_timing}, 32'd1);
          check("stop_bit", {31'd0, samples[9*C]}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_byte actual=%0h expected=none", data);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", {24'd0, data}, {24'd0, e.b});
            if (e.gap >= 0) check("idle_gap", idle_run, e.gap);
          end
          active = 1'b0; idle_run = 0;
        end
      end
    end
  end

  // busy/frame_done monitor: completion pulse shape and frame duration.
  initial begin
    int busy_run;
    logic prev_done;
    busy_run = 0; prev_done = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        busy_run = 0; prev_done = 1'b0;
      end else begin
        if (frame_done === 1'b1) begin
          done_count++;
          check("done_busy_low", {31'd0, busy}, 32'd0);
          check("done_tx_high", {31'd0, tx}, 32'd1);
          check("done_single_cycle", {31'd0, prev_done}, 32'd0);
          check("busy_duration", busy_run, FRAME_CYC);
        end
        if (busy === 1'b1) busy_run++;
        else busy_run = 0;
        prev_done = frame_done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nfr;
    reset_n = 1'b0; capture = 1'b0;
    probe1 = 1'b0; probe2 = 16'h0000; probe4 = 8'h00; probe5 = 8'h00;
    repeat (3) tick();
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, frame_done}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_stable", {29'd0, tx, busy, frame_done}, 32'h4);
    end

    run_frame(1'b1, 16'h1234, 8'h56, 8'h78, 0);
    run_frame(1'b1, 16'h1234, 8'h56, 8'h78, 1);
    run_frame(1'b0, 16'hAAAA, 8'h00, 8'h00, 0);
    for (int n = 0; n < 4; n++)
      run_frame(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 2);

    start_frame(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
    repeat (149) tick();
    reset_n = 1'b0;
    capture = 1'b1;
    exp_q.delete();
    exp_done--;
    tick();
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, frame_done}, 32'd0);
    tick();
    reset_n = 1'b1;
    capture = 1'b0;
    tick();
    check("abort_ignored_capture", {31'd0, busy}, 32'd0);
    run_frame(1'b1, 16'hBEEF, 8'hC3, 8'h3C, 0);

    nfr = 0;
    for (int k = 0; k * (FRAME_CYC + 1) < 600; k++) nfr++;
    probe1 = 1'b0; probe2 = 16'h0000; probe4 = 8'h00; probe5 = 8'h00;
    for (int k = 0; k < nfr; k++) push_frame(1'b0, 16'h0000, 8'h00, 8'h00, (k == 0) ? -1 : 1);
    capture = 1'b1;
    repeat (600) tick();
    capture = 1'b0;
    repeat (FRAME_CYC + 40) tick();

    check("pending_bytes", exp_q.size(), 0);
    check("frame_done_count", done_count, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/elbert_probe_tx.md
ELBERT_PROBE_TX -- requirements
Module: elbert_probe_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clock cycles per UART bit (12 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have port clock  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port capture  input  1  request to snapshot probes and send one frame.
REQ-005 SHALL have port probe1  input  1  single-bit circuit output under observation.
REQ-006 SHALL have port probe2  input  16  16-bit circuit output under observation.
REQ-007 SHALL have port probe4  input  8  8-bit circuit output under observation.
REQ-008 SHALL have port probe5  input  8  8-bit circuit output under observation.
REQ-009 SHALL have port tx  output  1  UART serial line to host, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is in flight.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 SHALL transmit each frame as 7 bytes in order: 0xA5, {7'b0,probe1}, probe2[15:8], probe2[7:0], probe4, probe5, checksum.
REQ-013 SHALL compute checksum as XOR of the 5 payload bytes (bytes 2..6), excluding 0xA5.
REQ-014 SHALL send each byte 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-015 SHALL accept capture only on a rising edge where busy=0; at that edge latch all probes into snapshot registers, set busy=1, drive tx=0 (start bit of byte 0).
REQ-016 SHALL ignore capture while busy=1; no queuing, no frame restart, snapshot unchanged.
REQ-017 SHALL transmit from the snapshot only; probe changes after the accept edge SHALL NOT affect the frame.
REQ-018 SHALL use FSM states IDLE, START, DATA, STOP with 3-bit byte index (0..6), 3-bit bit index (0..7), baud counter sized for CLKS_PER_BIT-1.
REQ-019 Transitions: IDLE->START on accepted capture; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8th bit period; STOP->START (byte index+1) if byte index<6; STOP->IDLE if byte index=6.
REQ-020 Frame duration SHALL be exactly 70*CLKS_PER_BIT cycles from accept edge to the edge where busy returns to 0.
REQ-021 At the edge ending the final stop bit: busy=0, frame_done=1 for exactly one cycle, tx=1.
REQ-022 Back-to-back: capture held high continuously SHALL start the next frame at the edge following the frame_done cycle, giving exactly one idle-high cycle between frames.
REQ-023 tx SHALL be driven from a register (glitch-free), never combinationally from state.

Reset
REQ-024 When reset_n=0 at a rising edge: state=IDLE, tx=1, busy=0, frame_done=0, counters and byte/bit indices=0, snapshot=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame at that edge (tx=1 next cycle, no frame_done pulse); capture during reset ignored.
REQ-026 First capture SHALL be accepted on the first edge with reset_n=1 and capture=1.

Verification (CLKS_PER_BIT=4)
REQ-027 Reset: hold reset_n=0 for 3 cycles -> tx=1, busy=0, frame_done=0; stays so with capture=0 for 50 cycles.
REQ-028 Single frame: probe1=1, probe2=0x1234, probe4=0x56, probe5=0x78, 1-cycle capture -> decoded bytes A5,01,12,34,56,78,09; busy high 280 cycles; one frame_done pulse.
REQ-029 Snapshot/ignore: after accept, change probes to 0/0xFFFF/0xFF/0xFF and pulse capture at cycle 100 -> frame bytes unchanged from REQ-028, only one frame_done.
REQ-030 Reset mid-frame: reset_n=0 at cycle 150 of a frame -> tx=1, busy=0 next cycle, no frame_done; fresh capture then yields a complete correct frame.
REQ-031 Back-to-back: capture held high for 600 cycles with probes all zero -> frames A5,00,00,00,00,00,00 with exactly one idle cycle between stop bit and next start bit.
REQ-032 Bit timing: every tx bit level held exactly 4 cycles, checked across a full frame with probe2=0xAAAA.
